// File: rtl/jlsemi_util_smic_efuse_loader.sv
// Sequencer in front of the SMIC eFuse adapter: autoloads every word into a shadow bank after reset,
// then serves software read/program requests, re-reading programmed words to check the burn.
module jlsemi_util_smic_efuse_loader #(
  parameter int          ADDR_WIDTH = 6,
  parameter int          NUM_WORDS  = 16,
  parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    reload,
  input  logic                    sw_req,
  input  logic                    sw_write,
  input  logic [ADDR_WIDTH-1:0]   sw_addr,
  input  logic [15:0]             sw_wdata,
  output logic                    sw_busy,
  output logic                    sw_done,
  output logic [15:0]             sw_rdata,
  output logic                    sw_err,
  output logic                    load_done,
  output logic                    tmo_err,
  output logic [NUM_WORDS*16-1:0] shadow_data,
  output logic                    efuse_en,
  output logic                    write_en,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [15:0]             wdata,
  input  logic [15:0]             rdata,
  input  logic                    rdata_vld,
  input  logic                    ready
);

  typedef enum logic [2:0] {
    IDLE, AL_REQ, AL_WAIT, SW_REQ, SW_WAIT, VF_REQ, VF_WAIT, DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   NW_EXT    = (ADDR_WIDTH + 1)'(NUM_WORDS);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  req_write_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [15:0]           req_wdata_q;
  logic [15:0]           buf_q, buf_nxt;
  logic [15:0]           pre_q;
  logic                  pre_seen_q;
  logic [15:0]           tmo_cnt_q;
  logic                  reload_pend_q;

  logic                  take_reload, oor, is_wait, last_word, accept;
  logic                  efuse_en_d, write_en_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [15:0]           wdata_d;
  logic                  shadow_we;
  logic [ADDR_WIDTH-1:0] shadow_waddr;

  // A word that arrives in the same cycle as ready must still land in the shadow bank.
  assign buf_nxt     = rdata_vld ? rdata : buf_q;
  assign take_reload = reload | reload_pend_q;
  assign oor         = ({1'b0, req_addr_q} >= NW_EXT);
  assign last_word   = (cnt_q == LAST_WORD);
  assign is_wait     = (state_q == AL_WAIT) || (state_q == SW_WAIT) || (state_q == VF_WAIT);
  assign accept      = (state_q == IDLE) && (state_d == SW_REQ);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= AL_REQ;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take_reload)             state_d = AL_REQ;
        else if (sw_req && load_done) state_d = SW_REQ;
      end
      AL_REQ:  state_d = AL_WAIT;
      AL_WAIT: if (ready) state_d = last_word ? IDLE : AL_REQ;
      SW_REQ:  state_d = oor ? DONE : SW_WAIT;
      SW_WAIT: if (ready) state_d = req_write_q ? VF_REQ : DONE;
      VF_REQ:  state_d = VF_WAIT;
      VF_WAIT: if (ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    efuse_en_d = 1'b0;
    write_en_d = write_en;
    addr_d     = addr;
    wdata_d    = wdata;
    case (state_q)
      AL_REQ: begin
        efuse_en_d = 1'b1;
        write_en_d = 1'b0;
        addr_d     = cnt_q;
        wdata_d    = 16'h0000;
      end
      SW_REQ: if (!oor) begin
        efuse_en_d = 1'b1;
        write_en_d = req_write_q;
        addr_d     = req_addr_q;
        wdata_d    = req_write_q ? req_wdata_q : 16'h0000;
      end
      VF_REQ: begin
        efuse_en_d = 1'b1;
        write_en_d = 1'b0;
        addr_d     = req_addr_q;
        wdata_d    = 16'h0000;
      end
      AL_WAIT, SW_WAIT, VF_WAIT: if (ready) begin
        write_en_d = 1'b0;
        addr_d     = '0;
        wdata_d    = 16'h0000;
      end
      default: ;
    endcase
    shadow_we    = ready && ((state_q == AL_WAIT) || (state_q == VF_WAIT) ||
                             ((state_q == SW_WAIT) && !req_write_q));
    shadow_waddr = (state_q == AL_WAIT) ? cnt_q : req_addr_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      efuse_en      <= 1'b0;
      write_en      <= 1'b0;
      addr          <= '0;
      wdata         <= 16'h0000;
      cnt_q         <= '0;
      req_write_q   <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= 16'h0000;
      buf_q         <= 16'h0000;
      pre_q         <= 16'h0000;
      pre_seen_q    <= 1'b0;
      tmo_cnt_q     <= 16'h0000;
      reload_pend_q <= 1'b0;
      sw_busy       <= 1'b0;
      sw_done       <= 1'b0;
      sw_rdata      <= 16'h0000;
      sw_err        <= 1'b0;
      load_done     <= 1'b0;
      tmo_err       <= 1'b0;
      shadow_data   <= '0;
    end else begin
      efuse_en <= efuse_en_d;
      write_en <= write_en_d;
      addr     <= addr_d;
      wdata    <= wdata_d;
      buf_q    <= buf_nxt;
      sw_done  <= (state_d == DONE);

      // Reloads seen mid-operation wait for the next IDLE visit.
      if (state_q == IDLE)  reload_pend_q <= 1'b0;
      else if (reload)      reload_pend_q <= 1'b1;

      if (state_q == IDLE && take_reload) begin
        cnt_q     <= '0;
        load_done <= 1'b0;
        tmo_err   <= 1'b0;
      end

      if (accept) begin
        req_write_q <= sw_write;
        req_addr_q  <= sw_addr;
        req_wdata_q <= sw_wdata;
        sw_busy     <= 1'b1;
      end
      if (state_q == DONE) sw_busy <= 1'b0;

      if (state_q == AL_REQ || state_q == SW_REQ || state_q == VF_REQ) begin
        tmo_cnt_q <= 16'h0000;
      end else if (is_wait && tmo_cnt_q != TIMEOUT) begin
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
        if ((tmo_cnt_q + 16'd1) == TIMEOUT) tmo_err <= 1'b1;
      end

      // The first word returned during a program access is the pre-burn image.
      if (state_q == SW_REQ) begin
        pre_q      <= 16'h0000;
        pre_seen_q <= 1'b0;
      end else if (state_q == SW_WAIT && rdata_vld && !pre_seen_q) begin
        pre_q      <= rdata;
        pre_seen_q <= 1'b1;
      end

      if (state_q == AL_WAIT && ready) begin
        if (last_word) load_done <= 1'b1;
        else           cnt_q     <= cnt_q + 1'b1;
      end

      if (state_q == SW_REQ && oor) sw_err <= 1'b1;
      if (state_q == SW_WAIT && ready && !req_write_q) begin
        sw_rdata <= buf_nxt;
        sw_err   <= 1'b0;
      end
      if (state_q == VF_WAIT && ready) begin
        sw_rdata <= buf_nxt;
        sw_err   <= (buf_nxt != (pre_q | req_wdata_q));
      end

      for (int i = 0; i < NUM_WORDS; i++) begin
        if (shadow_we && shadow_waddr == ADDR_WIDTH'(i)) shadow_data[16*i +: 16] <= buf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_jlsemi_util_smic_efuse_loader.sv
// Directed bench for the eFuse loader with a behavioural adapter model driving rdata/rdata_vld/ready.
module tb_jlsemi_util_smic_efuse_loader;
  localparam int AW = 6;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic reload = 1'b0, sw_req = 1'b0, sw_write = 1'b0;
  logic [AW-1:0] sw_addr = '0;
  logic [15:0] sw_wdata = 16'h0;
  logic sw_busy, sw_done, sw_err, load_done, tmo_err, efuse_en, write_en;
  logic [15:0] sw_rdata, wdata;
  logic [AW-1:0] addr;
  logic [NW*16-1:0] shadow_data;
  logic [15:0] rdata = 16'h0;
  logic rdata_vld = 1'b0, ready = 1'b0;

  int tests = 0, fails = 0;

  logic [15:0] mem [64];
  logic [15:0] burn_mask = 16'hFFFF;
  logic hold_ready = 1'b0;
  int proto_err = 0;
  logic busy_m = 1'b0;
  int cnt_m = 0;
  logic [AW-1:0] a_m = '0;
  logic w_m = 1'b0;
  logic [15:0] d_m = 16'h0;
  logic [AW-1:0] log_a[$];
  logic log_w[$];
  logic [15:0] log_d[$];

  always #5 clk = ~clk;

  jlsemi_util_smic_efuse_loader #(.ADDR_WIDTH(AW), .NUM_WORDS(NW), .TIMEOUT(16'd100)) dut (
    .clk(clk), .rstn(rstn), .reload(reload), .sw_req(sw_req), .sw_write(sw_write),
    .sw_addr(sw_addr), .sw_wdata(sw_wdata), .sw_busy(sw_busy), .sw_done(sw_done),
    .sw_rdata(sw_rdata), .sw_err(sw_err), .load_done(load_done), .tmo_err(tmo_err),
    .shadow_data(shadow_data), .efuse_en(efuse_en), .write_en(write_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rdata_vld(rdata_vld), .ready(ready)
  );

  // Adapter model: pre-image on rdata_vld two cycles after start, ready one cycle later.
  always @(negedge clk) begin
    if (!rstn) begin
      busy_m = 1'b0; ready = 1'b0; rdata_vld = 1'b0; rdata = 16'h0;
    end else begin
      rdata_vld = 1'b0;
      ready = 1'b0;
      if (efuse_en) begin
        if (busy_m) proto_err++;
        busy_m = 1'b1; cnt_m = 0; a_m = addr; w_m = write_en; d_m = wdata;
        log_a.push_back(addr); log_w.push_back(write_en); log_d.push_back(wdata);
      end else if (busy_m) begin
        if (addr !== a_m || write_en !== w_m || wdata !== d_m) proto_err++;
        cnt_m++;
        if (cnt_m == 2) begin
          rdata = mem[a_m]; rdata_vld = 1'b1;
          if (w_m) mem[a_m] = mem[a_m] | (d_m & burn_mask);
        end else if (cnt_m >= 3 && !hold_ready) begin
          ready = 1'b1; busy_m = 1'b0;
        end
      end else if (addr !== '0 || write_en !== 1'b0 || wdata !== 16'h0) begin
        proto_err++;
      end
    end
  end

  task automatic sw_access(input logic w, input logic [AW-1:0] a, input logic [15:0] d,
                           output int busy_lat, output int done_lat, output logic rdy_at_done);
    busy_lat = -1; done_lat = -1; rdy_at_done = 1'b0;
    sw_write = w; sw_addr = a; sw_wdata = d; sw_req = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (sw_busy && busy_lat < 0) begin busy_lat = k; sw_req = 1'b0; end
      if (sw_done) begin done_lat = k; rdy_at_done = ready; break; end
    end
    sw_req = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({efuse_en, write_en, sw_busy, sw_done, sw_err, load_done, tmo_err} !== 7'b0)
      begin fails++; $display("FAIL reset_flags got %b want 0000000", {efuse_en, write_en, sw_busy, sw_done, sw_err, load_done, tmo_err}); end
    tests++;
    if (shadow_data !== '0 || addr !== '0 || wdata !== 16'h0 || sw_rdata !== 16'h0)
      begin fails++; $display("FAIL reset_data shadow/addr/wdata/rdata not all zero addr=%h wdata=%h rdata=%h", addr, wdata, sw_rdata); end
  endtask

  task automatic test_autoload;
    int cyc;
    logic [15:0] prev15;
    logic [NW*16-1:0] exp_sh;
    int bad;
    log_a.delete(); log_w.delete(); log_d.delete();
    prev15 = 16'hxxxx;
    @(posedge clk); #1;
    rstn = 1'b1;
    cyc = 0;
    while (!load_done && cyc < 1000) begin
      prev15 = shadow_data[16*15 +: 16];
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if (!load_done) begin fails++; $display("FAIL autoload_done load_done=%b after %0d cycles want 1", load_done, cyc); end
    tests++;
    if (prev15 !== 16'h0 || shadow_data[16*15 +: 16] !== 16'hA50F)
      begin fails++; $display("FAIL autoload_last_edge word15 before=%h after=%h want 0000/a50f", prev15, shadow_data[16*15 +: 16]); end
    bad = 0;
    for (int i = 0; i < log_a.size(); i++) if (log_a[i] !== AW'(i) || log_w[i] !== 1'b0) bad++;
    tests++;
    if (log_a.size() != 16 || bad != 0) begin fails++; $display("FAIL autoload_seq got %0d reads (%0d bad) want 16 reads addr 0..15", log_a.size(), bad); end
    for (int i = 0; i < NW; i++) exp_sh[16*i +: 16] = 16'hA500 + 16'(i);
    tests++;
    if (shadow_data !== exp_sh) begin fails++; $display("FAIL autoload_shadow got %h want %h", shadow_data, exp_sh); end
    tests++;
    if (tmo_err !== 1'b0) begin fails++; $display("FAIL autoload_tmo got %b want 0", tmo_err); end
  endtask

  task automatic test_read;
    int bl, dl;
    logic rd;
    log_a.delete(); log_w.delete(); log_d.delete();
    sw_access(1'b0, 6'd3, 16'h0, bl, dl, rd);
    tests++;
    if (dl < 0 || bl != 1 || rd !== 1'b1) begin fails++; $display("FAIL read_timing busy_lat=%0d done_lat=%0d ready_at_done=%b want 1/>0/1", bl, dl, rd); end
    tests++;
    if (sw_rdata !== 16'hA503 || sw_err !== 1'b0) begin fails++; $display("FAIL read_data rdata=%h err=%b want a503/0", sw_rdata, sw_err); end
    tests++;
    if (log_a.size() != 1 || log_a[0] !== 6'd3 || log_w[0] !== 1'b0)
      begin fails++; $display("FAIL read_access got %0d accesses want one read at 3", log_a.size()); end
    @(posedge clk); #1;
    tests++;
    if (sw_done !== 1'b0 || sw_busy !== 1'b0) begin fails++; $display("FAIL read_release done=%b busy=%b want 0/0", sw_done, sw_busy); end
  endtask

  task automatic test_program;
    int bl, dl;
    logic rd;
    log_a.delete(); log_w.delete(); log_d.delete();
    sw_access(1'b1, 6'd5, 16'h0F00, bl, dl, rd);
    tests++;
    if (dl < 0 || rd !== 1'b1 || sw_rdata !== 16'hAF05 || sw_err !== 1'b0)
      begin fails++; $display("FAIL prog_ok done_lat=%0d rdata=%h err=%b want af05/0", dl, sw_rdata, sw_err); end
    tests++;
    if (shadow_data[16*5 +: 16] !== 16'hAF05) begin fails++; $display("FAIL prog_ok_shadow got %h want af05", shadow_data[16*5 +: 16]); end
    tests++;
    if (log_a.size() != 2 || log_a[0] !== 6'd5 || log_w[0] !== 1'b1 || log_d[0] !== 16'h0F00 ||
        log_a[1] !== 6'd5 || log_w[1] !== 1'b0 || log_d[1] !== 16'h0)
      begin fails++; $display("FAIL prog_ok_access got %0d accesses want program then read at 5", log_a.size()); end
    @(posedge clk); #1;
    burn_mask = 16'hFDFF;
    sw_access(1'b1, 6'd7, 16'h0F00, bl, dl, rd);
    burn_mask = 16'hFFFF;
    tests++;
    if (dl < 0 || sw_rdata !== 16'hAD07 || sw_err !== 1'b1)
      begin fails++; $display("FAIL prog_bad done_lat=%0d rdata=%h err=%b want ad07/1", dl, sw_rdata, sw_err); end
    tests++;
    if (shadow_data[16*7 +: 16] !== 16'hAD07) begin fails++; $display("FAIL prog_bad_shadow got %h want ad07", shadow_data[16*7 +: 16]); end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range;
    int bl, dl;
    logic rd;
    log_a.delete(); log_w.delete(); log_d.delete();
    sw_access(1'b0, 6'd20, 16'h0, bl, dl, rd);
    tests++;
    if (bl != 1 || dl != 2) begin fails++; $display("FAIL oor_timing busy_lat=%0d done_lat=%0d want 1/2", bl, dl); end
    tests++;
    if (sw_err !== 1'b1 || sw_rdata !== 16'hAD07) begin fails++; $display("FAIL oor_result err=%b rdata=%h want 1/ad07", sw_err, sw_rdata); end
    tests++;
    if (log_a.size() != 0) begin fails++; $display("FAIL oor_access got %0d accesses want 0", log_a.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    int k;
    int cyc;
    logic seen_done;
    logic first_ok;
    int bad;
    hold_ready = 1'b1;
    sw_write = 1'b0; sw_addr = 6'd2; sw_req = 1'b1;
    k = 0;
    while (!efuse_en && k < 20) begin @(posedge clk); #1; if (sw_busy) sw_req = 1'b0; k++; end
    sw_req = 1'b0;
    repeat (90) @(posedge clk);
    #1;
    tests++;
    if (tmo_err !== 1'b0) begin fails++; $display("FAIL tmo_early got %b want 0 after 90 wait cycles", tmo_err); end
    repeat (40) @(posedge clk);
    #1;
    tests++;
    if (tmo_err !== 1'b1 || sw_busy !== 1'b1 || sw_done !== 1'b0)
      begin fails++; $display("FAIL tmo_set tmo=%b busy=%b done=%b want 1/1/0", tmo_err, sw_busy, sw_done); end
    hold_ready = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 20 && !seen_done; i++) begin @(posedge clk); #1; seen_done = sw_done; end
    tests++;
    if (!seen_done || sw_rdata !== 16'hA502 || tmo_err !== 1'b1)
      begin fails++; $display("FAIL tmo_late_ready done=%b rdata=%h tmo=%b want 1/a502/1", seen_done, sw_rdata, tmo_err); end
    @(posedge clk); #1;
    log_a.delete(); log_w.delete(); log_d.delete();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    first_ok = (tmo_err === 1'b0 && load_done === 1'b0);
    cyc = 0;
    while (!load_done && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    tests++;
    if (!first_ok || !load_done) begin fails++; $display("FAIL reload_clear cleared=%b load_done=%b want 1/1", first_ok, load_done); end
    bad = 0;
    for (int i = 0; i < log_a.size(); i++) if (log_a[i] !== AW'(i) || log_w[i] !== 1'b0) bad++;
    tests++;
    if (log_a.size() != 16 || bad != 0 || tmo_err !== 1'b0)
      begin fails++; $display("FAIL reload_seq got %0d reads (%0d bad) tmo=%b want 16/0/0", log_a.size(), bad, tmo_err); end
    tests++;
    if (shadow_data[16*5 +: 16] !== 16'hAF05 || shadow_data[16*7 +: 16] !== 16'hAD07 || shadow_data[16*2 +: 16] !== 16'hA502)
      begin fails++; $display("FAIL reload_shadow w5=%h w7=%h w2=%h want af05/ad07/a502", shadow_data[16*5 +: 16], shadow_data[16*7 +: 16], shadow_data[16*2 +: 16]); end
  endtask

  task automatic test_back_to_back;
    int done_n, bad_accept, bad;
    logic saw_ld_low, prev_busy, first_seen;
    logic [15:0] rd0, rd1;
    log_a.delete(); log_w.delete(); log_d.delete();
    done_n = 0; bad_accept = 0; saw_ld_low = 1'b0; prev_busy = 1'b0; first_seen = 1'b0;
    rd0 = 16'h0; rd1 = 16'h0;
    hold_ready = 1'b1;
    sw_write = 1'b0; sw_addr = 6'd4; sw_req = 1'b1;
    for (int k = 1; k <= 600 && done_n < 2; k++) begin
      @(posedge clk); #1;
      if (sw_busy && !first_seen) begin first_seen = 1'b1; sw_addr = 6'd1; end
      if (k == 6) reload = 1'b1;
      if (k == 7) begin reload = 1'b0; hold_ready = 1'b0; end
      if (!load_done) saw_ld_low = 1'b1;
      if (sw_busy && !prev_busy && !load_done) bad_accept++;
      prev_busy = sw_busy;
      if (sw_done) begin
        if (done_n == 0) rd0 = sw_rdata; else begin rd1 = sw_rdata; sw_req = 1'b0; end
        done_n++;
      end
    end
    sw_req = 1'b0; reload = 1'b0; hold_ready = 1'b0;
    tests++;
    if (done_n != 2 || rd0 !== 16'hA504 || rd1 !== 16'hA501)
      begin fails++; $display("FAIL b2b_done count=%0d rdata0=%h rdata1=%h want 2/a504/a501", done_n, rd0, rd1); end
    bad = 0;
    if (log_a.size() == 18) begin
      if (log_a[0] !== 6'd4 || log_a[17] !== 6'd1) bad++;
      for (int i = 1; i <= 16; i++) if (log_a[i] !== AW'(i - 1)) bad++;
      for (int i = 0; i < 18; i++) if (log_w[i] !== 1'b0) bad++;
    end
    tests++;
    if (log_a.size() != 18 || bad != 0) begin fails++; $display("FAIL b2b_order got %0d accesses (%0d bad) want 4,0..15,1", log_a.size(), bad); end
    tests++;
    if (bad_accept != 0 || !saw_ld_low) begin fails++; $display("FAIL b2b_gate early_accepts=%0d reload_seen=%b want 0/1", bad_accept, saw_ld_low); end
    tests++;
    if (proto_err != 0) begin fails++; $display("FAIL protocol got %0d adapter protocol errors want 0", proto_err); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = (i < NW) ? 16'hA500 + 16'(i) : 16'h0000;
    test_reset();
    test_autoload();
    test_read();
    test_program();
    test_out_of_range();
    test_timeout();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end
endmodule
